// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the animated sprite renderer.
// Imported by the top level and the frame sequencer.
package sprite_pkg;

    typedef enum logic [1:0] {
        ANIM_HOLD     = 2'd0,
        ANIM_LOOP     = 2'd1,
        ANIM_ONCE     = 2'd2,
        ANIM_PINGPONG = 2'd3
    } anim_mode_e;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } anim_dir_e;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COLOR_W  = 4;

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation frame sequencer: counts video frames and steps the sprite frame
// index in hold / loop / once / ping-pong order, only on frame_start.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8,
    parameter int FIDX_W      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              anim_restart,
    input  anim_mode_e        anim_mode,
    output logic [FIDX_W-1:0] frame_idx,
    output logic              anim_done
);

    localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);
    localparam logic [FIDX_W-1:0] LAST_IDX  = FIDX_W'(FRAMES - 1);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [FIDX_W-1:0] idx_q, idx_d;
    anim_dir_e         dir_q, dir_d;
    logic              done_q, done_d;

    always_comb begin
        tick_d = tick_q;
        idx_d  = idx_q;
        dir_d  = dir_q;
        if (anim_restart) begin
            tick_d = '0;
            idx_d  = '0;
            dir_d  = DIR_FWD;
        end else if (frame_start) begin
            if (tick_q == LAST_TICK) begin
                tick_d = '0;
                if (FRAMES > 1) begin
                    case (anim_mode)
                        ANIM_LOOP: idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        ANIM_ONCE: if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
                        ANIM_PINGPONG: begin
                            // Endpoints turn the direction so they are shown once per sweep.
                            if (dir_q == DIR_FWD) begin
                                if (idx_q == LAST_IDX) begin
                                    dir_d = DIR_REV;
                                    idx_d = idx_q - 1'b1;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    dir_d = DIR_FWD;
                                    idx_d = idx_q + 1'b1;
                                end else begin
                                    idx_d = idx_q - 1'b1;
                                end
                            end
                        end
                        default: idx_d = idx_q;
                    endcase
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
        done_d = (anim_mode == ANIM_ONCE) && (idx_d == LAST_IDX) && !anim_restart;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            idx_q  <= '0;
            dir_q  <= DIR_FWD;
            done_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
            idx_q  <= idx_d;
            dir_q  <= dir_d;
            done_q <= done_d;
        end
    end

    assign frame_idx = idx_q;
    assign anim_done = done_q;

endmodule

// File: rtl/sprite_animator.sv
// Animated sprite renderer: shadowed placement, scaled/flipped ROM addressing
// and transparent compositing over the background, two pixel clocks deep.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int SPRITE_W    = 20,
    parameter int SPRITE_H    = 10,
    parameter int FRAMES      = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int FRAME_TICKS = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT_IDX = '0,
    parameter int ADDR_W      = $clog2(FRAMES * SPRITE_W * SPRITE_H)
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank,
    input  logic               frame_start,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic               flip_h,
    input  logic [1:0]         anim_mode,
    input  logic               anim_restart,
    input  logic [COLOR_W-1:0] bg_r,
    input  logic [COLOR_W-1:0] bg_g,
    input  logic [COLOR_W-1:0] bg_b,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_q,
    output logic [COLOR_W-1:0] pal_index,
    input  logic [COLOR_W-1:0] pal_r,
    input  logic [COLOR_W-1:0] pal_g,
    input  logic [COLOR_W-1:0] pal_b,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               sprite_hit,
    output logic               anim_done
);

    localparam int BOX_W      = SPRITE_W << SCALE_SHIFT;
    localparam int BOX_H      = SPRITE_H << SCALE_SHIFT;
    localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;
    localparam int FIDX_W     = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [FIDX_W-1:0] frame_idx;

    sprite_anim_seq #(
        .FRAMES     (FRAMES),
        .FRAME_TICKS(FRAME_TICKS),
        .FIDX_W     (FIDX_W)
    ) u_seq (
        .clk         (vga_clk),
        .rst_n       (reset_n),
        .frame_start (frame_start),
        .anim_restart(anim_restart),
        .anim_mode   (anim_mode_e'(anim_mode)),
        .frame_idx   (frame_idx),
        .anim_done   (anim_done)
    );

    logic [9:0]         pos_x_q, pos_x_d;
    logic [9:0]         pos_y_q, pos_y_d;
    logic               flip_q, flip_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               in_box_q, in_box_d;
    logic               blank_q, blank_d;
    logic [COLOR_W-1:0] bg_r_q, bg_g_q, bg_b_q;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               hit_q, hit_d;

    logic [10:0] x11, y11, px11, py11, dx, dy, lx, ly, lx_sel;
    logic        drawn;

    always_comb begin
        pos_x_d = frame_start ? pos_x  : pos_x_q;
        pos_y_d = frame_start ? pos_y  : pos_y_q;
        flip_d  = frame_start ? flip_h : flip_q;

        // 11-bit compare so a box hanging past the right/bottom edge never wraps.
        x11  = {1'b0, DrawX};
        y11  = {1'b0, DrawY};
        px11 = {1'b0, pos_x_q};
        py11 = {1'b0, pos_y_q};
        in_box_d = (x11 >= px11) && (x11 < px11 + 11'(BOX_W)) && (x11 < 11'(H_ACTIVE))
                && (y11 >= py11) && (y11 < py11 + 11'(BOX_H)) && (y11 < 11'(V_ACTIVE));

        dx     = x11 - px11;
        dy     = y11 - py11;
        lx     = dx >> SCALE_SHIFT;
        ly     = dy >> SCALE_SHIFT;
        lx_sel = flip_q ? (11'(SPRITE_W - 1) - lx) : lx;

        rom_addr_d = rom_addr_q;
        if (in_box_d) begin
            rom_addr_d = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE)
                       + ADDR_W'(ly) * ADDR_W'(SPRITE_W)
                       + ADDR_W'(lx_sel);
        end
        blank_d = blank;

        drawn   = blank_q && in_box_q && (rom_q != TRANSPARENT_IDX);
        hit_d   = drawn;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (drawn) begin
            red_d   = pal_r;
            green_d = pal_g;
            blue_d  = pal_b;
        end else if (blank_q) begin
            red_d   = bg_r_q;
            green_d = bg_g_q;
            blue_d  = bg_b_q;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            flip_q     <= 1'b0;
            rom_addr_q <= '0;
            in_box_q   <= 1'b0;
            blank_q    <= 1'b0;
            bg_r_q     <= '0;
            bg_g_q     <= '0;
            bg_b_q     <= '0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            hit_q      <= 1'b0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            flip_q     <= flip_d;
            rom_addr_q <= rom_addr_d;
            in_box_q   <= in_box_d;
            blank_q    <= blank_d;
            bg_r_q     <= bg_r;
            bg_g_q     <= bg_g;
            bg_b_q     <= bg_b;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            hit_q      <= hit_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pal_index  = rom_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed placement/flip/edge/reset steps plus a
// random pixel stream, scored against a texel-level model of the sprite.
module tb_sprite_animator;
    import sprite_pkg::*;

    localparam int SW = 20;
    localparam int SH = 10;
    localparam int NF = 4;
    localparam int SS = 1;
    localparam int FT = 2;
    localparam int AW = 10;
    localparam int BOX_W = SW * (1 << SS);
    localparam int BOX_H = SH * (1 << SS);

    logic          vga_clk, reset_n;
    logic [9:0]    DrawX, DrawY, pos_x, pos_y;
    logic          blank, frame_start, flip_h, anim_restart;
    logic [1:0]    anim_mode;
    logic [3:0]    bg_r, bg_g, bg_b, rom_q, pal_index, pal_r, pal_g, pal_b;
    logic [AW-1:0] rom_addr;
    logic [3:0]    red, green, blue;
    logic          sprite_hit, anim_done;

    logic [3:0] rom [0:NF*SW*SH-1];

    function automatic logic [11:0] pal_rgb(input logic [3:0] i);
        return {i, i ^ 4'hA, ~i};
    endfunction

    // rom_addr is the ROM's address register, so data follows it combinationally.
    assign rom_q = rom[rom_addr];
    assign {pal_r, pal_g, pal_b} = pal_rgb(pal_index);

    sprite_animator #(
        .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(NF), .SCALE_SHIFT(SS),
        .FRAME_TICKS(FT), .TRANSPARENT_IDX(4'd0)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
        .flip_h(flip_h), .anim_mode(anim_mode), .anim_restart(anim_restart),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .rom_addr(rom_addr), .rom_q(rom_q),
        .pal_index(pal_index), .pal_r(pal_r), .pal_g(pal_g), .pal_b(pal_b),
        .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit),
        .anim_done(anim_done)
    );

    // ---------------- clock ----------------
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ---------------- reference model ----------------
    int         n_cmp = 0;
    int         n_mis = 0;
    int         m_px, m_py, m_n, m_addr;
    bit         m_flip;
    anim_mode_e m_mode;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pix_q[$];

    function automatic int model_idx();
        int steps = m_n / FT;
        int p;
        case (m_mode)
            ANIM_LOOP: return steps % NF;
            ANIM_ONCE: return (steps < NF - 1) ? steps : NF - 1;
            ANIM_PINGPONG: begin
                p = steps % (2 * NF - 2);
                return (p < NF) ? p : 2 * NF - 2 - p;
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [12:0] model_pixel(input int x, input int y, input bit bl,
                                                input logic [11:0] bg);
        bit in_box;
        int lx, ly;
        logic [3:0] texel;
        in_box = x >= m_px && x < m_px + BOX_W && y >= m_py && y < m_py + BOX_H
              && x < H_ACTIVE && y < V_ACTIVE;
        if (in_box) begin
            lx = (x - m_px) / (1 << SS);
            ly = (y - m_py) / (1 << SS);
            if (m_flip) lx = SW - 1 - lx;
            m_addr = model_idx() * SW * SH + ly * SW + lx;
        end
        texel = rom[m_addr];
        if (bl && in_box && texel != 4'd0) return {1'b1, pal_rgb(texel)};
        if (bl) return {1'b0, bg};
        return 13'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pix(input int x, input int y, input bit bl);
        logic [11:0] bg;
        logic [31:0] e;
        if (exp_addr_q.size() > 0) check("rom_addr", 32'(rom_addr), exp_addr_q.pop_front());
        if (exp_pix_q.size() >= 2) begin
            e = exp_pix_q.pop_front();
            check("pixel", 32'({sprite_hit, red, green, blue}), e);
        end
        bg    = 12'($urandom);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        {bg_r, bg_g, bg_b} = bg;
        exp_pix_q.push_back(32'(model_pixel(x, y, bl, bg)));
        exp_addr_q.push_back(32'(m_addr));
        @(negedge vga_clk);
    endtask

    task automatic flush();
        pix(700, 500, 1'b0);
        pix(700, 500, 1'b0);
        exp_addr_q.delete();
        exp_pix_q.delete();
    endtask

    task automatic pulse(input bit restart);
        frame_start  = 1'b1;
        anim_restart = restart;
        @(negedge vga_clk);
        frame_start  = 1'b0;
        anim_restart = 1'b0;
        m_px = pos_x; m_py = pos_y; m_flip = flip_h;
        if (restart) m_n = 0; else m_n++;
    endtask

    task automatic set_mode(input anim_mode_e m);
        anim_mode = m;
        m_mode    = m;
    endtask

    task automatic check_done();
        check("anim_done", 32'(anim_done),
              32'((m_mode == ANIM_ONCE) && (model_idx() == NF - 1)));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NF * SW * SH; i++) rom[i] = 4'($urandom_range(0, 15));
        rom[0] = 4'd5; rom[19] = 4'd9; rom[20] = 4'd0; rom[200] = 4'd7;

        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0; frame_start = 1'b0;
        pos_x = '0; pos_y = '0; flip_h = 1'b0; anim_restart = 1'b0;
        bg_r = '0; bg_g = '0; bg_b = '0;
        set_mode(ANIM_HOLD);
        m_px = 0; m_py = 0; m_flip = 0; m_n = 0; m_addr = 0;
        repeat (3) @(negedge vga_clk);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_rgb_hit", 32'({sprite_hit, red, green, blue}), 32'd0);
        check("reset_anim_done", 32'(anim_done), 32'd0);
        reset_n = 1'b1;
        @(negedge vga_clk);

        // Placement, right edge of box, transparency and blanking.
        pos_x = 10'd100; pos_y = 10'd50;
        pulse(1'b0);
        pix(100, 50, 1'b1);
        pix(139, 50, 1'b1);
        pix(140, 50, 1'b1);
        pix(100, 52, 1'b1);
        pix(102, 50, 1'b0);
        pix(99, 69, 1'b1);
        pix(139, 69, 1'b1);
        flush();

        // Flip, then a mid-frame move that must stay hidden until frame_start.
        flip_h = 1'b1;
        pulse(1'b0);
        pix(100, 50, 1'b1);
        pos_x = 10'd200;
        pix(100, 50, 1'b1);
        pix(121, 51, 1'b1);
        pix(200, 50, 1'b1);
        flush();
        pulse(1'b0);
        pix(200, 50, 1'b1);
        pix(100, 50, 1'b1);
        pix(239, 69, 1'b1);
        flush();

        for (int i = 0; i < 80; i++)
            pix($urandom_range(190, 250), $urandom_range(44, 76), 1'($urandom_range(0, 3) != 0));
        flush();

        // Loop sequencing.
        flip_h = 1'b0; pos_x = '0; pos_y = '0;
        set_mode(ANIM_LOOP);
        pulse(1'b1);
        for (int i = 0; i < 10; i++) begin
            pulse(1'b0);
            pix(0, 0, 1'b1);
            pix(39, 19, 1'b1);
            flush();
        end

        // Once: saturate, then leaving once mode clears anim_done.
        set_mode(ANIM_ONCE);
        pulse(1'b1);
        for (int i = 0; i < 8; i++) begin
            pulse(1'b0);
            check_done();
            pix(0, 0, 1'b1);
            flush();
        end
        check("once_done_final", 32'(anim_done), 32'd1);
        set_mode(ANIM_LOOP);
        @(negedge vga_clk);
        check("done_drop", 32'(anim_done), 32'd0);

        // Ping-pong.
        set_mode(ANIM_PINGPONG);
        pulse(1'b1);
        for (int i = 0; i < 14; i++) begin
            pulse(1'b0);
            pix(0, 0, 1'b1);
            pix(5, 3, 1'b1);
            flush();
        end

        // Restart colliding with a stepping frame_start.
        set_mode(ANIM_LOOP);
        pulse(1'b1);
        pulse(1'b0);
        pulse(1'b1);
        pix(0, 0, 1'b1);
        flush();
        for (int i = 0; i < 2; i++) begin
            pulse(1'b0);
            pix(0, 0, 1'b1);
            flush();
        end

        // Clipping at the bottom-right corner.
        set_mode(ANIM_HOLD);
        pos_x = 10'd630; pos_y = 10'd475;
        pulse(1'b1);
        for (int x = 625; x < 646; x++) pix(x, 475, 1'b1);
        for (int x = 0; x < 10; x++) pix(x, 475, 1'b1);
        for (int y = 0; y < 5; y++) pix(632, y, 1'b1);
        pix(634, 479, 1'b1);
        pix(634, 480, 1'b1);
        flush();

        // Reset in the middle of a line.
        pix(631, 476, 1'b1);
        pix(632, 476, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_rom_addr", 32'(rom_addr), 32'd0);
        check("midreset_rgb_hit", 32'({sprite_hit, red, green, blue}), 32'd0);
        check("midreset_anim_done", 32'(anim_done), 32'd0);
        m_px = 0; m_py = 0; m_flip = 0; m_n = 0; m_addr = 0;
        exp_addr_q.delete();
        exp_pix_q.delete();
        @(negedge vga_clk);
        reset_n = 1'b1;
        pix(0, 0, 1'b1);
        pix(5, 3, 1'b1);
        pix(631, 476, 1'b1);
        flush();
        pulse(1'b0);
        pix(630, 475, 1'b1);
        pix(639, 479, 1'b1);
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sprite_animator.md
Name: sprite_animator

Overview:
- Parametrised successor of the full-screen sprite stretcher.
- Draws one animated sprite at a movable (x,y) position, with power-of-two scaling, horizontal flip, transparent-index compositing over a background colour, and loop/once/ping-pong frame sequencing.
- Sits between the VGA controller and the colour mux; drives an external synchronous sprite ROM and combinational palette.

Parameters:
- SPRITE_W, 20, sprite width in texels
- SPRITE_H, 10, sprite height in texels
- FRAMES, 4, number of animation frames stored back-to-back in ROM
- SCALE_SHIFT, 1, on-screen texel size is 2^SCALE_SHIFT pixels square
- FRAME_TICKS, 8, video frames each animation frame is held
- TRANSPARENT_IDX, 0, palette index treated as see-through
- ADDR_W, $clog2(FRAMES*SPRITE_W*SPRITE_H), ROM address width

Ports:
- vga_clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pos_x  in  10  sprite top-left column (live, shadowed)
- pos_y  in  10  sprite top-left row (live, shadowed)
- flip_h  in  1  mirror horizontally (shadowed)
- anim_mode  in  2  0 = hold, 1 = loop, 2 = once, 3 = ping-pong
- anim_restart  in  1  pulse: frame index to 0, direction forward
- bg_r/bg_g/bg_b  in  4 each  background colour, aligned with DrawX/DrawY
- rom_addr  out  ADDR_W  ROM address, registered
- rom_q  in  4  ROM data, valid one vga_clk after rom_addr
- pal_index  out  4  equals rom_q, feeds palette
- pal_r/pal_g/pal_b  in  4 each  palette colour (combinational from pal_index)
- red/green/blue  out  4 each  composited pixel, registered
- sprite_hit  out  1  opaque sprite pixel drawn, aligned with red/green/blue
- anim_done  out  1  level: once-mode reached last frame

Behaviour:
- Reset (async, reset_n=0): all outputs 0. Shadow regs 0. frame_idx 0. tick_cnt 0. Direction forward.
- Shadowing: pos_x, pos_y, flip_h sampled only on the frame_start cycle; mid-frame changes are not visible until the next frame_start.
- Pipeline, latency 2 from DrawX/DrawY to red/green/blue/sprite_hit:
  - S0: compute in_box, local coordinates and rom_addr; register rom_addr, in_box, blank, bg.
  - S1: rom_q valid. Drawn pixel = blank_d & in_box_d & (rom_q != TRANSPARENT_IDX).
  - Register outputs: pal colour if drawn, else bg_d if blank_d, else 0. sprite_hit = drawn.
- Hit test uses 11-bit unsigned arithmetic to avoid wrap:
  - in_box = DrawX >= px && DrawX < px + (SPRITE_W<<SCALE_SHIFT); same rule for Y.
  - A sprite extending past 639/479 is clipped, with no wrap to column/row 0.
- Addressing:
  - lx = (DrawX-px)>>SCALE_SHIFT; ly likewise.
  - With flip: lx' = SPRITE_W-1-lx.
  - rom_addr = frame_idx*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx'.
  - When out of box, rom_addr holds its previous value.
- Animation: on each frame_start, tick_cnt increments.
  - When tick_cnt reaches FRAME_TICKS-1 it clears to 0 and the frame steps per anim_mode.
  - hold: no step.
  - loop: idx+1, wrapping FRAMES-1 to 0.
  - once: idx+1, saturating at FRAMES-1; anim_done=1 while idx==FRAMES-1 in once mode.
  - ping-pong: forward to FRAMES-1, then reverse to 0, then forward. Endpoints are shown once per cycle (0,1,2,3,2,1,0,1...).
  - FRAMES==1: idx stays 0 in all modes.
- frame_idx changes only on frame_start, so no tearing.
- anim_restart has priority over a simultaneous frame_start step: idx 0, tick_cnt 0, forward, anim_done 0.
- Mode change takes effect at the next step; if the new mode is not once, anim_done drops immediately.
- Reset mid-frame: outputs 0 at once; rendering resumes correctly on the next valid pixel. Shadow regs stay 0 until the next frame_start.

Decomposition:
- Package sprite_pkg holds:
  - the anim_mode_e enum (ANIM_HOLD, ANIM_LOOP, ANIM_ONCE, ANIM_PINGPONG)
  - the screen constants H_ACTIVE=640 and V_ACTIVE=480
  - the colour width constant (4)
- One sub-module, sprite_anim_seq: owns tick_cnt, frame_idx, direction and anim_done; outputs frame_idx.
- The top level holds the shadow regs, address pipeline and compositor.

Test Plan:
- Place pos=(100,50), SCALE_SHIFT=1, mode hold, ROM texel(0,0)=5. Then (DrawX,DrawY)=(100,50) → rom_addr 0 after 1 clk; red/green/blue = palette[5] and sprite_hit=1 after 2 clks. (139,50) → addr 19; (140,50) → bg colour, hit 0.
- Flip: flip_h=1, same pos, pixel (100,50) → rom_addr 19. Change pos_x to 200 mid-frame → drawing stays at 100 until after frame_start.
- Transparency and blank: texel index 0 inside box → bg output, hit 0. blank=0 inside box → output 0.
- Loop: FRAMES=4, FRAME_TICKS=2, 10 frame_start pulses → idx sequence 0,0,1,1,2,2,3,3,0,0. Frame 1 pixel (0,0) → rom_addr 200.
- Once and ping-pong:
  - once with 8 pulses → idx saturates at 3, anim_done=1.
  - ping-pong with 14 pulses → idx 0,0,1,1,2,2,3,3,2,2,1,1,0,0.
  - anim_restart on the same cycle as a stepping frame_start → idx 0.
- Edge/reset: pos=(630,475) → pixels at x≥630 drawn up to 639; no pixel at x<10 hit. Assert reset_n low mid-line → all outputs 0 in the same cycle, idx 0.
